// File: rtl/dct_transpose_pingpong_buf.sv
// Ping-pong NxN transpose buffer between the DCT row and column passes.
// Each bank keeps its beats as written; a transposed read gathers elements across the bank.
module dct_transpose_pingpong_buf #(
    parameter int DATA_WIDTH = 8,
    parameter int N          = 8,
    parameter int LANES      = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [DATA_WIDTH*N*LANES-1:0] s_data,
    input  logic                          s_col_mode,
    input  logic                          s_transpose,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [DATA_WIDTH*N*LANES-1:0] m_data,
    output logic                          m_last,
    output logic [1:0]                    buf_level
);

    localparam int BPB       = N / LANES;
    localparam int BW        = (BPB > 1) ? $clog2(BPB) : 1;
    localparam int BEAT_BITS = DATA_WIDTH * N * LANES;
    localparam int BANK_BITS = BEAT_BITS * BPB;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BPB - 1);

    typedef enum logic [1:0] {
        BANK_EMPTY,
        BANK_FILLING,
        BANK_FULL,
        BANK_DRAINING
    } bank_state_t;

    bank_state_t          state_q [2];
    bank_state_t          state_d [2];
    logic                 wr_bank_q;
    logic                 rd_bank_q;
    logic [BW-1:0]        wr_beat_q;
    logic [BW-1:0]        rd_beat_q;
    logic                 col_mode_q  [2];
    logic                 transpose_q [2];
    logic [BEAT_BITS-1:0] mem [2][BPB];

    logic                 wr_fire;
    logic                 rd_fire;
    logic                 wr_last;
    logic                 rd_last;
    logic                 wr_open;
    logic                 rd_busy;
    logic                 busy0;
    logic                 busy1;
    logic [BANK_BITS-1:0] bank_flat;
    logic [BEAT_BITS-1:0] xposed;

    assign wr_open = (state_q[wr_bank_q] == BANK_EMPTY) || (state_q[wr_bank_q] == BANK_FILLING);
    assign rd_busy = (state_q[rd_bank_q] == BANK_FULL)  || (state_q[rd_bank_q] == BANK_DRAINING);
    assign busy0   = (state_q[0] == BANK_FULL) || (state_q[0] == BANK_DRAINING);
    assign busy1   = (state_q[1] == BANK_FULL) || (state_q[1] == BANK_DRAINING);

    assign s_ready   = rst_n & wr_open;
    assign m_valid   = rd_busy;
    assign wr_fire   = s_valid & s_ready;
    assign rd_fire   = m_valid & m_ready;
    assign wr_last   = (wr_beat_q == LAST_BEAT);
    assign rd_last   = (rd_beat_q == LAST_BEAT);
    assign m_last    = m_valid & rd_last;
    assign buf_level = {1'b0, busy0} + {1'b0, busy1};

    // Write and read never target the same bank: one needs EMPTY/FILLING, the other FULL/DRAINING.
    always_comb begin
        state_d[0] = state_q[0];
        state_d[1] = state_q[1];
        if (wr_fire) begin
            state_d[wr_bank_q] = wr_last ? BANK_FULL : BANK_FILLING;
        end
        if (rd_fire) begin
            state_d[rd_bank_q] = rd_last ? BANK_EMPTY : BANK_DRAINING;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q[0] <= BANK_EMPTY;
            state_q[1] <= BANK_EMPTY;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            wr_beat_q  <= '0;
            rd_beat_q  <= '0;
        end else begin
            state_q[0] <= state_d[0];
            state_q[1] <= state_d[1];
            if (wr_fire) begin
                if (wr_last) begin
                    wr_beat_q <= '0;
                    wr_bank_q <= ~wr_bank_q;
                end else begin
                    wr_beat_q <= wr_beat_q + 1'b1;
                end
            end
            if (rd_fire) begin
                if (rd_last) begin
                    rd_beat_q <= '0;
                    rd_bank_q <= ~rd_bank_q;
                end else begin
                    rd_beat_q <= rd_beat_q + 1'b1;
                end
            end
        end
    end

    // NOTE: storage and per-bank mode bits carry no reset; bank state alone says whether contents are valid.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_bank_q][wr_beat_q] <= s_data;
            if (wr_beat_q == '0) begin
                col_mode_q[wr_bank_q]  <= s_col_mode;
                transpose_q[wr_bank_q] <= s_transpose;
            end
        end
    end

    // Stored vector s sits at bank_flat[s*N*DATA_WIDTH +: N*DATA_WIDTH], in the write orientation.
    always_comb begin
        bank_flat = '0;
        for (int b = 0; b < BPB; b++) begin
            bank_flat[b*BEAT_BITS +: BEAT_BITS] = mem[rd_bank_q][BW'(b)];
        end
    end

    // Transposed output vector v element i is stored vector i element v.
    always_comb begin
        xposed = '0;
        for (int j = 0; j < LANES; j++) begin
            for (int i = 0; i < N; i++) begin
                xposed[(j*N + i)*DATA_WIDTH +: DATA_WIDTH] =
                    bank_flat[(i*N + int'(rd_beat_q)*LANES + j)*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // col_mode XOR transpose differs from the write orientation exactly when transpose is set.
    assign m_data = transpose_q[rd_bank_q] ? xposed : mem[rd_bank_q][rd_beat_q];

endmodule

// File: tb/tb_dct_transpose_pingpong_buf.sv
// Directed bench for dct_transpose_pingpong_buf with word(r,c) = base + 8r + c.
module tb_dct_transpose_pingpong_buf;

    localparam int DW    = 8;
    localparam int N     = 8;
    localparam int LANES = 2;
    localparam int BPB   = N / LANES;
    localparam int W     = DW * N * LANES;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] s_data;
    logic         s_col_mode;
    logic         s_transpose;
    logic         m_valid;
    logic         m_ready;
    logic [W-1:0] m_data;
    logic         m_last;
    logic [1:0]   buf_level;

    int tests  = 0;
    int fails  = 0;
    int wr_acc = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (s_valid && s_ready) wr_acc <= wr_acc + 1;
    end

    dct_transpose_pingpong_buf #(.DATA_WIDTH(DW), .N(N), .LANES(LANES)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_col_mode (s_col_mode),
        .s_transpose(s_transpose),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .buf_level  (buf_level)
    );

    // Beat k of the block in orientation orient (0 = rows, 1 = columns).
    function automatic logic [W-1:0] block_beat(input int base, input logic orient, input int k);
        logic [W-1:0] r;
        int v;
        int val;
        r = '0;
        for (int j = 0; j < LANES; j++) begin
            for (int i = 0; i < N; i++) begin
                v   = k * LANES + j;
                val = orient ? (base + N*i + v) : (base + N*v + i);
                r[(j*N + i)*DW +: DW] = DW'(val);
            end
        end
        return r;
    endfunction

    task automatic send_block(input int base, input logic col, input logic tr,
                              input logic late_col, input logic late_tr,
                              input int first, input int nbeats, input bit no_stall);
        for (int k = first; k < first + nbeats; k++) begin
            int guard = 0;
            s_valid     = 1'b1;
            s_data      = block_beat(base, col, k);
            s_col_mode  = (k == 0) ? col : late_col;
            s_transpose = (k == 0) ? tr  : late_tr;
            @(negedge clk);
            while (!s_ready && guard < 200) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 200) begin
                tests++; fails++;
                $display("FAIL write_timeout base=%0d beat=%0d: s_ready=0 after 200 cycles, required 1", base, k);
                s_valid = 1'b0;
                return;
            end
            if (no_stall) begin
                tests++;
                if (guard != 0) begin
                    fails++;
                    $display("FAIL write_stall base=%0d beat=%0d: stalled %0d cycles, required 0", base, k, guard);
                end
            end
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
    endtask

    task automatic recv_block(input int base, input logic orient, input bit first_immediate);
        for (int k = 0; k < BPB; k++) begin
            int guard = 0;
            logic [W-1:0] exp_data;
            exp_data = block_beat(base, orient, k);
            @(negedge clk);
            while (!(m_valid && m_ready) && guard < 200) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 200) begin
                tests++; fails++;
                $display("FAIL read_timeout base=%0d beat=%0d: m_valid=0 after 200 cycles, required 1", base, k);
                return;
            end
            if (first_immediate || k > 0) begin
                tests++;
                if (guard != 0) begin
                    fails++;
                    $display("FAIL read_bubble base=%0d beat=%0d: waited %0d cycles, required 0", base, k, guard);
                end
            end
            tests++;
            if (m_data !== exp_data) begin
                fails++;
                $display("FAIL read_data base=%0d beat=%0d: got %h, required %h", base, k, m_data, exp_data);
            end
            tests++;
            if (m_last !== (k == BPB - 1)) begin
                fails++;
                $display("FAIL read_last base=%0d beat=%0d: got %b, required %b", base, k, m_last, (k == BPB - 1));
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_col_mode = 1'b0; s_transpose = 1'b0; m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (s_ready !== 1'b0) begin fails++; $display("FAIL reset_s_ready: got %b, required 0", s_ready); end
        tests++;
        if (m_valid !== 1'b0) begin fails++; $display("FAIL reset_m_valid: got %b, required 0", m_valid); end
        rst_n = 1'b1;
        #1;
        tests++;
        if (s_ready !== 1'b1) begin fails++; $display("FAIL reset_release_s_ready: got %b, required 1", s_ready); end
        tests++;
        if (buf_level !== 2'd0) begin fails++; $display("FAIL reset_buf_level: got %0d, required 0", buf_level); end
        tests++;
        if (m_last !== 1'b0) begin fails++; $display("FAIL reset_m_last: got %b, required 0", m_last); end
    endtask

    task automatic test_row_transpose();
        m_ready = 1'b1;
        send_block(0, 1'b0, 1'b1, 1'b0, 1'b1, 0, 3, 1'b0);
        tests++;
        if (m_valid !== 1'b0) begin fails++; $display("FAIL early_m_valid: got %b, required 0", m_valid); end
        send_block(0, 1'b0, 1'b1, 1'b0, 1'b1, 3, 1, 1'b0);
        tests++;
        if (m_valid !== 1'b1) begin fails++; $display("FAIL latency_m_valid: got %b, required 1", m_valid); end
        tests++;
        if (buf_level !== 2'd1) begin fails++; $display("FAIL level_one: got %0d, required 1", buf_level); end
        recv_block(0, 1'b1, 1'b1);
        tests++;
        if (m_valid !== 1'b0 || buf_level !== 2'd0) begin
            fails++;
            $display("FAIL drained_empty: m_valid=%b level=%0d, required 0 and 0", m_valid, buf_level);
        end
    endtask

    task automatic test_col_modes();
        m_ready = 1'b1;
        send_block(0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 4, 1'b0);
        recv_block(0, 1'b1, 1'b1);
        send_block(0, 1'b1, 1'b1, 1'b1, 1'b1, 0, 4, 1'b0);
        recv_block(0, 1'b0, 1'b1);
    endtask

    task automatic test_backpressure();
        int acc0;
        m_ready = 1'b0;
        acc0 = wr_acc;
        fork
            begin
                send_block(0,   1'b0, 1'b1, 1'b0, 1'b1, 0, 4, 1'b0);
                send_block(64,  1'b0, 1'b1, 1'b0, 1'b1, 0, 4, 1'b0);
                send_block(128, 1'b0, 1'b1, 1'b0, 1'b1, 0, 4, 1'b0);
            end
            begin
                repeat (15) @(posedge clk);
                #1;
                tests++;
                if (wr_acc - acc0 !== 8) begin fails++; $display("FAIL full_accepted: got %0d beats, required 8", wr_acc - acc0); end
                tests++;
                if (s_ready !== 1'b0) begin fails++; $display("FAIL full_s_ready: got %b, required 0", s_ready); end
                tests++;
                if (buf_level !== 2'd2) begin fails++; $display("FAIL full_level: got %0d, required 2", buf_level); end
                m_ready = 1'b1;
                recv_block(0, 1'b1, 1'b1);
                tests++;
                if (s_ready !== 1'b1) begin fails++; $display("FAIL reopen_s_ready: got %b, required 1", s_ready); end
                tests++;
                if (buf_level !== 2'd1) begin fails++; $display("FAIL reopen_level: got %0d, required 1", buf_level); end
                recv_block(64, 1'b1, 1'b1);
                recv_block(128, 1'b1, 1'b0);
            end
        join
    endtask

    task automatic test_back_to_back();
        m_ready = 1'b1;
        fork
            begin
                for (int b = 0; b < 5; b++) begin
                    logic c;
                    logic t;
                    c = ((b % 2) == 1);
                    t = (((b / 2) % 2) == 1);
                    send_block(40*b, c, t, c, t, 0, 4, 1'b1);
                end
            end
            begin
                for (int b = 0; b < 5; b++) begin
                    logic o;
                    o = ((b % 2) == 1) ^ (((b / 2) % 2) == 1);
                    recv_block(40*b, o, (b > 0));
                end
            end
        join
    endtask

    task automatic test_mode_latch();
        m_ready = 1'b1;
        send_block(0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 4, 1'b0);
        recv_block(0, 1'b1, 1'b1);
        send_block(0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 4, 1'b0);
        recv_block(0, 1'b0, 1'b1);
    endtask

    task automatic test_mid_reset();
        m_ready = 1'b0;
        send_block(0,  1'b0, 1'b0, 1'b0, 1'b0, 0, 4, 1'b0);
        send_block(64, 1'b1, 1'b0, 1'b1, 1'b0, 0, 2, 1'b0);
        tests++;
        if (buf_level !== 2'd1 || m_valid !== 1'b1) begin
            fails++;
            $display("FAIL prereset_state: level=%0d m_valid=%b, required 1 and 1", buf_level, m_valid);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (s_ready !== 1'b0) begin fails++; $display("FAIL in_reset_s_ready: got %b, required 0", s_ready); end
        @(posedge clk);
        #1;
        tests++;
        if (m_valid !== 1'b0) begin fails++; $display("FAIL mid_reset_m_valid: got %b, required 0", m_valid); end
        tests++;
        if (buf_level !== 2'd0) begin fails++; $display("FAIL mid_reset_level: got %0d, required 0", buf_level); end
        tests++;
        if (m_last !== 1'b0) begin fails++; $display("FAIL mid_reset_m_last: got %b, required 0", m_last); end
        tests++;
        if (s_ready !== 1'b0) begin fails++; $display("FAIL mid_reset_s_ready: got %b, required 0", s_ready); end
        rst_n = 1'b1;
        #1;
        tests++;
        if (s_ready !== 1'b1) begin fails++; $display("FAIL post_reset_s_ready: got %b, required 1", s_ready); end
        send_block(100, 1'b1, 1'b1, 1'b1, 1'b1, 0, 4, 1'b0);
        tests++;
        if (m_valid !== 1'b1 || buf_level !== 2'd1) begin
            fails++;
            $display("FAIL post_reset_block: m_valid=%b level=%0d, required 1 and 1", m_valid, buf_level);
        end
        m_ready = 1'b1;
        recv_block(100, 1'b0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_row_transpose();
        test_col_modes();
        test_backpressure();
        test_back_to_back();
        test_mode_latch();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at 200000, required completion");
        $fatal(1, "global timeout");
    end

endmodule
